// File: rtl/mips_debug_ctrl_if.sv
// mips_debug_ctrl_if
// Bundles every non-clock signal of the debug sequencer: UART rx/tx
// handshakes, pipeline enable/halt/PC, instruction-memory write port and
// register-file debug read port.
//   slave  : view of the sequencer (mips_debug_ctrl)
//   master : view of the surrounding system (UART pair, MIPS core, memories)
interface mips_debug_ctrl_if #(
    parameter int LEN          = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_IMEM_ADDR = 10,
    parameter int NB_BYTE      = 8
) ();
    logic [NB_BYTE-1:0]      i_rx_data;
    logic                    i_rx_valid;
    logic [NB_BYTE-1:0]      o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_pipe_en;
    logic                    i_halt;
    logic [LEN-1:0]          i_pc;
    logic                    o_imem_we;
    logic [NB_IMEM_ADDR-1:0] o_imem_addr;
    logic [LEN-1:0]          o_imem_data;
    logic [NB_ADDR-1:0]      o_reg_dbg_addr;
    logic [LEN-1:0]          i_reg_dbg_data;
    logic                    o_busy;

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_done, i_halt, i_pc, i_reg_dbg_data,
        output o_tx_data, o_tx_start, o_pipe_en, o_imem_we, o_imem_addr,
               o_imem_data, o_reg_dbg_addr, o_busy
    );

    modport master (
        output i_rx_data, i_rx_valid, i_tx_done, i_halt, i_pc, i_reg_dbg_data,
        input  o_tx_data, o_tx_start, o_pipe_en, o_imem_we, o_imem_addr,
               o_imem_data, o_reg_dbg_addr, o_busy
    );
endinterface

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl
// Run-control / debug sequencer for the 5-stage MIPS. Accepts byte commands
// from the UART receiver: 'L' loads program words into instruction memory,
// 'C' runs until HALT, 'S' single-steps, 'D' dumps only. Every run/step ends
// with a dump of reg0..reg31, PC and the cycle counter (34 words, LSB first).
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-low reset
//   bus    : mips_debug_ctrl_if.slave (UART rx/tx, pipe enable/halt/PC,
//            imem write port, register-file debug port, busy)
module mips_debug_ctrl #(
    parameter int          LEN          = 32,
    parameter int          NB_ADDR      = 5,
    parameter int          NB_IMEM_ADDR = 10,
    parameter int          NB_BYTE      = 8,
    parameter logic [7:0]  CMD_LOAD     = 8'h4C,
    parameter logic [7:0]  CMD_RUN      = 8'h43,
    parameter logic [7:0]  CMD_STEP     = 8'h53,
    parameter logic [7:0]  CMD_DUMP     = 8'h44
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mips_debug_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_CNT  = 4'd1,
        ST_LOAD_BYTE = 4'd2,
        ST_LOAD_WR   = 4'd3,
        ST_RUN       = 4'd4,
        ST_STEP      = 4'd5,
        ST_DUMP_ADDR = 4'd6,
        ST_DUMP_SEND = 4'd7,
        ST_DUMP_WAIT = 4'd8
    } state_t;

    localparam logic [5:0] PC_WORD   = 6'd32;
    localparam logic [5:0] LAST_WORD = 6'd33;

    state_t                  state_q, state_d;
    logic [NB_BYTE-1:0]      cnt_q, cnt_d;          // words left to load
    logic [NB_IMEM_ADDR-1:0] waddr_q, waddr_d;      // imem write address
    logic [1:0]              bidx_q, bidx_d;        // byte index inside a word
    logic [LEN-1:0]          word_q, word_d;        // load assembly / dump latch
    logic [5:0]              widx_q, widx_d;        // dump word index 0..33
    logic [LEN-1:0]          cycle_q, cycle_d;
    logic                    pipe_en_q, pipe_en_d;
    logic                    tx_start_q, tx_start_d;
    logic [NB_BYTE-1:0]      tx_data_q, tx_data_d;
    logic                    imem_we_q, imem_we_d;
    logic [NB_ADDR-1:0]      dbg_addr_q, dbg_addr_d;
    logic                    busy_q, busy_d;
    logic [LEN-1:0]          src_word_s;

    // Next-state and next-output logic for the command sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        waddr_d    = waddr_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        widx_d     = widx_q;
        cycle_d    = cycle_q + {{(LEN-1){1'b0}}, pipe_en_q};
        pipe_en_d  = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        imem_we_d  = 1'b0;
        dbg_addr_d = dbg_addr_q;
        src_word_s = word_q;

        case (state_q)
            ST_IDLE: begin
                // Dump pointers are parked at zero so any dump starts at reg0.
                widx_d     = 6'd0;
                bidx_d     = 2'd0;
                dbg_addr_d = '0;
                if (bus.i_rx_valid) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: state_d = ST_LOAD_CNT;
                        // Enable is registered, so raising it here makes it
                        // high in the first RUN/STEP cycle.
                        CMD_RUN: begin
                            state_d   = ST_RUN;
                            pipe_en_d = 1'b1;
                        end
                        CMD_STEP: begin
                            state_d   = ST_STEP;
                            pipe_en_d = 1'b1;
                        end
                        CMD_DUMP: state_d = ST_DUMP_ADDR;
                        default:  state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_CNT: begin
                if (bus.i_rx_valid) begin
                    if (bus.i_rx_data == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = bus.i_rx_data;
                        waddr_d = '0;
                        bidx_d  = 2'd0;
                        state_d = ST_LOAD_BYTE;
                    end
                end else begin
                    state_d = ST_LOAD_CNT;
                end
            end
            ST_LOAD_BYTE: begin
                if (bus.i_rx_valid) begin
                    word_d[{bidx_q, 3'b000} +: NB_BYTE] = bus.i_rx_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d   = ST_LOAD_WR;
                        imem_we_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD_BYTE;
                    end
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_LOAD_WR: begin
                waddr_d = waddr_q + {{(NB_IMEM_ADDR-1){1'b0}}, 1'b1};
                cnt_d   = cnt_q - {{(NB_BYTE-1){1'b0}}, 1'b1};
                if (cnt_q == {{(NB_BYTE-1){1'b0}}, 1'b1}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD_BYTE;
                end
            end
            ST_RUN: begin
                // The edge that samples halt is the last one the pipe advances on.
                if (bus.i_halt) begin
                    state_d = ST_DUMP_ADDR;
                end else begin
                    pipe_en_d = 1'b1;
                end
            end
            ST_STEP:      state_d = ST_DUMP_ADDR;
            ST_DUMP_ADDR: state_d = ST_DUMP_SEND;
            ST_DUMP_SEND: begin
                // Latch the source word only on byte 0; bytes 1..3 reuse it.
                if (bidx_q == 2'd0) begin
                    if (widx_q < PC_WORD) begin
                        src_word_s = bus.i_reg_dbg_data;
                    end else if (widx_q == PC_WORD) begin
                        src_word_s = bus.i_pc;
                    end else begin
                        src_word_s = cycle_q;
                    end
                end else begin
                    src_word_s = word_q;
                end
                word_d     = src_word_s;
                tx_data_d  = src_word_s[{bidx_q, 3'b000} +: NB_BYTE];
                tx_start_d = 1'b1;
                state_d    = ST_DUMP_WAIT;
            end
            ST_DUMP_WAIT: begin
                if (bus.i_tx_done) begin
                    if (bidx_q != 2'd3) begin
                        bidx_d  = bidx_q + 2'd1;
                        state_d = ST_DUMP_SEND;
                    end else if (widx_q == LAST_WORD) begin
                        bidx_d  = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        bidx_d     = 2'd0;
                        widx_d     = widx_q + 6'd1;
                        dbg_addr_d = widx_d[NB_ADDR-1:0];
                        state_d    = ST_DUMP_ADDR;
                    end
                end else begin
                    state_d = ST_DUMP_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output flops; reset aborts any operation at once.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            waddr_q    <= '0;
            bidx_q     <= 2'd0;
            word_q     <= '0;
            widx_q     <= 6'd0;
            cycle_q    <= '0;
            pipe_en_q  <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            imem_we_q  <= 1'b0;
            dbg_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            waddr_q    <= waddr_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            widx_q     <= widx_d;
            cycle_q    <= cycle_d;
            pipe_en_q  <= pipe_en_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            imem_we_q  <= imem_we_d;
            dbg_addr_q <= dbg_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_tx_start     = tx_start_q;
    assign bus.o_pipe_en      = pipe_en_q;
    assign bus.o_imem_we      = imem_we_q;
    assign bus.o_imem_addr    = waddr_q;
    assign bus.o_imem_data    = word_q;
    assign bus.o_reg_dbg_addr = dbg_addr_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl
// Directed stimulus with a scoreboard: expected imem writes and tx bytes are
// queued when stimulus is issued; monitor processes pop and compare whenever
// the DUT presents an imem write or a tx start.
`timescale 1ns/1ps
module tb_mips_debug_ctrl;
    localparam logic [31:0] PC_VAL = 32'h0000_0ABC;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_debug_ctrl_if bus ();
    logic [31:0] regs [32];
    assign bus.i_reg_dbg_data = regs[bus.o_reg_dbg_addr];

    mips_debug_ctrl dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pipe_cnt = 0;
    logic [41:0] exp_wr_q [$];
    logic [7:0]  exp_tx_q [$];
    logic [7:0]  tx_hist  [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: imem writes, tx bytes, pipe-enable cycles.
    initial begin
        logic [41:0] ew;
        forever begin
            @(negedge clk);
            if (bus.o_pipe_en === 1'b1) pipe_cnt++;
            if (bus.o_imem_we === 1'b1) begin
                if (exp_wr_q.size() == 0) begin
                    check("imem_unexpected_write", {bus.o_imem_addr, bus.o_imem_data}, 64'h0);
                end else begin
                    ew = exp_wr_q.pop_front();
                    check("imem_write", {bus.o_imem_addr, bus.o_imem_data}, ew);
                end
            end
            if (bus.o_tx_start === 1'b1) begin
                tx_hist.push_back(bus.o_tx_data);
                if (exp_tx_q.size() == 0) begin
                    check("tx_unexpected_byte", bus.o_tx_data, 64'h100);
                end else begin
                    check("tx_byte", bus.o_tx_data, exp_tx_q.pop_front());
                end
            end
        end
    end

    // UART transmitter model: answers each start with a delayed done and
    // checks data stays stable with no new start in between.
    initial begin
        logic [7:0] held;
        bit         ok;
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start === 1'b1) begin
                held = bus.o_tx_data;
                ok   = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (bus.o_tx_start !== 1'b0 || bus.o_tx_data !== held) ok = 1'b0;
                end
                bus.i_tx_done = 1'b1;
                @(negedge clk);
                bus.i_tx_done = 1'b0;
                check("tx_hold_until_done", {63'd0, ok}, 64'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[b*8 +: 8]);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.o_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", {63'd0, (n >= budget)}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic push_dump(input logic [31:0] cyc);
        logic [31:0] w;
        for (int i = 0; i < 34; i++) begin
            w = (i < 32) ? regs[i] : ((i == 32) ? PC_VAL : cyc);
            for (int b = 0; b < 4; b++) exp_tx_q.push_back(w[b*8 +: 8]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tx_data"},  bus.o_tx_data,      64'd0);
        check({tag, "_tx_start"}, bus.o_tx_start,     64'd0);
        check({tag, "_pipe_en"},  bus.o_pipe_en,      64'd0);
        check({tag, "_imem_we"},  bus.o_imem_we,      64'd0);
        check({tag, "_imem_addr"},bus.o_imem_addr,    64'd0);
        check({tag, "_imem_data"},bus.o_imem_data,    64'd0);
        check({tag, "_dbg_addr"}, bus.o_reg_dbg_addr, 64'd0);
        check({tag, "_busy"},     bus.o_busy,         64'd0);
    endtask

    task automatic check_dump_tail(input string name, input int base, input logic [31:0] cyc);
        if (tx_hist.size() < base + 136) begin
            check({name, "_dump_length"}, tx_hist.size() - base, 64'd136);
        end else begin
            check(name, {tx_hist[base+135], tx_hist[base+134], tx_hist[base+133], tx_hist[base+132]}, cyc);
        end
    endtask

    initial begin
        logic [31:0] lw [3];
        int pbase;
        int tbase;
        lw[0] = 32'hA1B2_C3D4;
        lw[1] = 32'h0BAD_F00D;
        lw[2] = 32'h0000_0001;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i + 32'h1000_0000;
        regs[5] = 32'hDEAD_BEEF;
        rst_n          = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_halt     = 1'b0;
        bus.i_pc       = PC_VAL;

        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of LOAD_BYTE after two bytes.
        send_byte(8'h4C); send_byte(8'd3); send_byte(8'h78); send_byte(8'h56);
        check("busy_during_load", bus.o_busy, 64'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midload_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single word load after reset.
        exp_wr_q.push_back({10'd0, 32'h1234_5678});
        send_byte(8'h4C); send_byte(8'd1);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        wait_idle(50);
        check("load1_all_writes_seen", exp_wr_q.size(), 64'd0);

        // Three-word load.
        for (int i = 0; i < 3; i++) exp_wr_q.push_back({10'(i), lw[i]});
        send_byte(8'h4C); send_byte(8'd3);
        for (int i = 0; i < 3; i++) send_word(lw[i]);
        wait_idle(100);
        check("load3_all_writes_seen", exp_wr_q.size(), 64'd0);

        // Zero-length load: back to idle the next cycle.
        send_byte(8'h4C); send_byte(8'd0);
        check("load0_busy_low", bus.o_busy, 64'd0);

        // Unknown byte in IDLE is ignored.
        send_byte(8'h58);
        check("unknown_cmd_busy", bus.o_busy, 64'd0);

        // Two single steps.
        pbase = pipe_cnt; tbase = tx_hist.size();
        push_dump(32'd1);
        send_byte(8'h53);
        wait_idle(3000);
        check("step1_pipe_cycles", pipe_cnt - pbase, 64'd1);
        check("step1_dump_done", exp_tx_q.size(), 64'd0);
        check_dump_tail("step1_cycle_count", tbase, 32'd1);

        pbase = pipe_cnt; tbase = tx_hist.size();
        push_dump(32'd2);
        send_byte(8'h53);
        wait_idle(3000);
        check("step2_pipe_cycles", pipe_cnt - pbase, 64'd1);
        check_dump_tail("step2_cycle_count", tbase, 32'd2);

        // Dump only: reg5 bytes and frozen pipeline.
        pbase = pipe_cnt; tbase = tx_hist.size();
        push_dump(32'd2);
        send_byte(8'h44);
        wait_idle(3000);
        check("dump_pipe_frozen", pipe_cnt - pbase, 64'd0);
        if (tx_hist.size() < tbase + 24) begin
            check("dump_reg5_length", tx_hist.size() - tbase, 64'd136);
        end else begin
            check("dump_reg5_byte20", tx_hist[tbase+20], 64'hEF);
            check("dump_reg5_byte21", tx_hist[tbase+21], 64'hBE);
            check("dump_reg5_byte22", tx_hist[tbase+22], 64'hAD);
            check("dump_reg5_byte23", tx_hist[tbase+23], 64'hDE);
        end
        check_dump_tail("dump_cycle_count", tbase, 32'd2);

        // Reset clears the counter, then continuous run halted after 20 cycles,
        // with an 'L' arriving mid-run that must be ignored.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        pbase = pipe_cnt; tbase = tx_hist.size();
        push_dump(32'd20);
        send_byte(8'h43);
        repeat (5) @(negedge clk);
        send_byte(8'h4C);
        check("run_ignores_rx_pipe_en", bus.o_pipe_en, 64'd1);
        repeat (12) @(negedge clk);
        bus.i_halt = 1'b1;
        wait_idle(3000);
        bus.i_halt = 1'b0;
        check("run_pipe_cycles", pipe_cnt - pbase, 64'd20);
        check("run_dump_done", exp_tx_q.size(), 64'd0);
        check_dump_tail("run_cycle_count", tbase, 32'd20);
        check("run_no_imem_write", exp_wr_q.size(), 64'd0);

        // Halt already high on entry: exactly one advance.
        pbase = pipe_cnt; tbase = tx_hist.size();
        bus.i_halt = 1'b1;
        push_dump(32'd21);
        send_byte(8'h43);
        wait_idle(3000);
        bus.i_halt = 1'b0;
        check("run_halted_pipe_cycles", pipe_cnt - pbase, 64'd1);
        check_dump_tail("run_halted_cycle_count", tbase, 32'd21);
        check("final_idle_busy", bus.o_busy, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
Run-control and debug sequencer for the 5-stage MIPS pipeline. It takes byte commands from the UART receiver, loads program words into instruction memory, and gates pipeline advance through a global enable. The enable supports continuous run until HALT or single-step. After a run or step it dumps the register file, PC and cycle count back through the UART transmitter. It sits between the UART rx/tx pair and the top-level MIPS, and owns the register-file debug read port.

Parameters:
LEN, 32, datapath/register word width
NB_ADDR, 5, register-file address width
NB_IMEM_ADDR, 10, instruction-memory word address width
NB_BYTE, 8, UART byte width
CMD_LOAD, 8'h4C, 'L': load program
CMD_RUN, 8'h43, 'C': continuous run
CMD_STEP, 8'h53, 'S': single step
CMD_DUMP, 8'h44, 'D': dump only

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  1-cycle strobe: i_rx_data valid
o_tx_data  out  8  byte to transmit
o_tx_start  out  1  1-cycle strobe: start transmit
i_tx_done  in  1  1-cycle strobe: previous byte sent
o_pipe_en  out  1  pipeline/PC advance enable (registered)
i_halt  in  1  HALT instruction reached writeback
i_pc  in  LEN  current PC
o_imem_we  out  1  instruction-memory write strobe
o_imem_addr  out  NB_IMEM_ADDR  instruction-memory write address
o_imem_data  out  LEN  instruction word to write
o_reg_dbg_addr  out  NB_ADDR  register-file debug read address
i_reg_dbg_data  in  LEN  register-file debug read data (combinational)
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, i_rst=0): state IDLE; all outputs 0; cycle counter, byte index and word counter cleared. Reset mid-operation aborts immediately. A partially assembled word is discarded.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, DUMP_ADDR, DUMP_SEND, DUMP_WAIT.
- IDLE: acts only on i_rx_valid.
  - CMD_LOAD → LOAD_CNT; CMD_RUN → RUN; CMD_STEP → STEP; CMD_DUMP → DUMP_ADDR.
  - Any other byte is ignored; the block stays in IDLE.
- LOAD_CNT: the next rx byte N is the word count. N=0 → IDLE with no writes. Otherwise set word address to 0 → LOAD_BYTE.
- LOAD_BYTE: assembles 4 bytes, LSB first.
  - After the 4th byte → LOAD_WR.
  - LOAD_WR: o_imem_we=1 for exactly 1 cycle with the current address/data. Then address+1 (wraps at 2^NB_IMEM_ADDR) and count−1. Count reaches 0 → IDLE, else → LOAD_BYTE.
- RUN: o_pipe_en=1 from the cycle after entry.
  - If i_halt is sampled 1 at edge k, o_pipe_en is 0 after edge k. The pipeline therefore advances on edge k and no further. Next state DUMP_ADDR.
  - If i_halt is already 1 on entry, the pipeline advances exactly one cycle, then dumps.
- STEP: o_pipe_en=1 for exactly one cycle regardless of i_halt → DUMP_ADDR.
- Cycle counter: LEN bits, +1 on every cycle o_pipe_en=1, wraps at 2^LEN. Cleared only by reset.
- Dump sequence: 34 words = reg0..reg31, then i_pc, then cycle count. Each word is sent LSB first, 136 bytes total.
  - DUMP_ADDR: drive o_reg_dbg_addr = word index, for 1 cycle.
  - DUMP_SEND: latch the word (register data, i_pc, or counter), present byte 0, pulse o_tx_start for 1 cycle → DUMP_WAIT.
  - DUMP_WAIT: on i_tx_done, send the next byte of the word (back to DUMP_SEND for bytes 1..3 without re-latching). After the 4th byte, the next word goes via DUMP_ADDR. After byte 136 → IDLE.
- o_tx_data is held stable from o_tx_start until i_tx_done.
- i_rx_valid is ignored in RUN, STEP and the dump states; no command queueing.
- i_tx_done outside DUMP_WAIT is ignored.
- o_pipe_en is 0 in every state except RUN/STEP as specified, so the pipeline is frozen during load and dump.

Test Plan:
- Reset during LOAD_BYTE after 2 bytes → all outputs 0, IDLE. A following 'L',1,78,56,34,12 → one o_imem_we pulse, addr 0, data 32'h12345678.
- 'L',3 + 12 bytes → 3 write pulses at addr 0,1,2 with correct words. 'L',0 → no write, o_busy low the next cycle.
- 'C' with i_halt raised 20 cycles after entry → o_pipe_en high 20 cycles then 0. 136 tx bytes follow; the last 4 bytes encode cycle count 20.
- 'S' twice → each gives exactly one o_pipe_en cycle and a full 136-byte dump. The second dump's cycle count is 2.
- Dump with reg5=32'hDEADBEEF → bytes 20..23 = EF, BE, AD, DE. No new o_tx_start occurs before i_tx_done.
- Byte 8'h58 in IDLE and 'L' received during RUN → both ignored; no state change, no imem write.
